// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants and enums for the ALU operation sequencer and its ALU.
package alu_op_sequencer_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_RES_W  = 2 * DEF_DATA_W;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_OR  = 2'd1,
        ALU_AND = 2'd2,
        ALU_CAT = 2'd3
    } alu_func_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Upstream operation and downstream result handshakes of the sequencer.
// master = the side issuing operations / consuming results, slave = sequencer.
interface alu_op_sequencer_if
    import alu_op_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    localparam int RES_W = 2 * DATA_W;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [1:0]        in_func;
    logic              in_use_acc;

    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_data;

    modport master (
        output in_valid, in_a, in_b, in_func, in_use_acc, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, in_func, in_use_acc, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/alu_op_sequencer_alu.sv
// Combinational 4-bit ALU driven by the sequencer's registered operands.
// OR/AND reduce across both operands; the result is a 0/1 flag.
module alu_op_sequencer_alu
    import alu_op_sequencer_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    localparam int RES_W  = 2 * DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        func,
    output logic [RES_W-1:0]  result
);

    // Function select; the sum is kept at full width so it never saturates.
    always_comb begin
        result = '0;
        case (alu_func_t'(func))
            ALU_ADD: result = RES_W'(a) + RES_W'(b);
            ALU_OR:  result = RES_W'(|{a, b});
            ALU_AND: result = RES_W'(&{a, b});
            ALU_CAT: result = {a, b};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer around an external combinational ALU: registers operands on
// accept, captures the result one edge later and holds it until consumed.
// The last result is kept as an accumulator whose low nibble can replace B.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    localparam int RES_W  = 2 * DATA_W
) (
    input  logic              Clock,
    input  logic              Resetn,
    alu_op_sequencer_if.slave op,
    input  logic              acc_clr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_func,
    input  logic [RES_W-1:0]  alu_result,
    output logic [RES_W-1:0]  acc
);

    seq_state_t state;
    logic       accept;

    // Ready in IDLE, or in HOLD when the held result leaves on this same edge.
    // Gated by Resetn so nothing is accepted while reset is asserted.
    assign op.in_ready = Resetn & ((state == IDLE) | ((state == HOLD) & op.out_ready));
    assign accept      = op.in_valid & op.in_ready;

    // FSM, operand registers, result capture and accumulator.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state        <= IDLE;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_func     <= '0;
            op.out_data  <= '0;
            op.out_valid <= 1'b0;
            acc          <= '0;
        end else begin
            // Operands only move on accept so the ALU inputs stay steady per op.
            // B sees acc as it stands at this edge (the result being consumed).
            if (accept) begin
                alu_a    <= op.in_a;
                alu_func <= op.in_func;
                alu_b    <= op.in_use_acc ? acc[DATA_W-1:0] : op.in_b;
            end

            // Clear beats a coincident capture for acc only.
            if (acc_clr)
                acc <= '0;
            else if (state == EXEC)
                acc <= alu_result;

            case (state)
                IDLE: begin
                    if (accept)
                        state <= EXEC;
                end
                EXEC: begin
                    op.out_data  <= alu_result;
                    op.out_valid <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (op.out_ready) begin
                        op.out_valid <= 1'b0;
                        state        <= accept ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
